awaddr_ddr_fifo_aw_issuer: RTL and testbench

//  Read-side drain engine for the AW-address DDR FIFO. Pops {len,addr} words from the FIFO read port,

---
 rtl/awaddr_ddr_fifo_aw_issuer.sv | 101 ++++++++++
 tb/tb_awaddr_ddr_fifo_aw_issuer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/awaddr_ddr_fifo_aw_issuer.sv
// AW-address DDR FIFO drain engine: pops {len,addr} words into a 2-entry prefetch queue and
// issues them as AXI4 AW beats, throttled by the count of bursts still awaiting a B response.
module awaddr_ddr_fifo_aw_issuer #(
   parameter int         c_ADDR_WIDTH   = 28,
   parameter int         c_LEN_WIDTH    = 4,
   parameter int         c_ID_WIDTH     = 4,
   parameter int         c_AWID         = 0,
   parameter logic [2:0] c_AWSIZE       = 3'd5,
   parameter int         c_MAX_OUTSTAND = 8
) (
   input  logic                                rd_clk,
   input  logic                                rd_rst,
   input  logic [c_ADDR_WIDTH+c_LEN_WIDTH-1:0] fifo_rd_data,
   input  logic                                fifo_rd_empty,
   output logic                                fifo_rd_en,
   output logic [c_ID_WIDTH-1:0]               m_axi_awid,
   output logic [c_ADDR_WIDTH-1:0]             m_axi_awaddr,
   output logic [7:0]                          m_axi_awlen,
   output logic [2:0]                          m_axi_awsize,
   output logic [1:0]                          m_axi_awburst,
   output logic                                m_axi_awvalid,
   input  logic                                m_axi_awready,
   input  logic                                m_axi_bvalid,
   input  logic [1:0]                          m_axi_bresp,
   output logic                                m_axi_bready,
   output logic [7:0]                          outstanding,
   output logic                                err_bresp,
   output logic                                err_unexp_b,
   output logic                                idle
);

   localparam logic [7:0] MAX_O = 8'(c_MAX_OUTSTAND);

   typedef struct packed {
      logic [c_LEN_WIDTH-1:0]  len;
      logic [c_ADDR_WIDTH-1:0] addr;
   } aw_ent_t;

   aw_ent_t    q0, q1, din;
   logic [1:0] occ;
   logic       pop_pending, run, hs, b_acc;

   assign din = aw_ent_t'(fifo_rd_data);
   assign hs  = m_axi_awvalid && m_axi_awready;
   assign b_acc = m_axi_bvalid && run;

   // A same-cycle dequeue frees a slot, which keeps the pop stream gapless under awready=1.
   assign fifo_rd_en = run && !fifo_rd_empty &&
                       (({1'b0, occ} + {2'b00, pop_pending} - {2'b00, hs}) < 3'd2);

   assign m_axi_awvalid = run && (occ != 2'd0) && (outstanding < MAX_O);
   assign m_axi_awaddr  = q0.addr;
   assign m_axi_awlen   = 8'(q0.len);
   assign m_axi_awid    = c_ID_WIDTH'(c_AWID);
   assign m_axi_awsize  = c_AWSIZE;
   assign m_axi_awburst = 2'b01;
   assign m_axi_bready  = run;
   assign idle          = (occ == 2'd0) && !pop_pending && (outstanding == 8'd0);

   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         run         <= 1'b0;
         pop_pending <= 1'b0;
         occ         <= 2'd0;
         q0          <= '0;
         q1          <= '0;
         outstanding <= 8'd0;
         err_bresp   <= 1'b0;
         err_unexp_b <= 1'b0;
      end else begin
         run         <= 1'b1;
         pop_pending <= fifo_rd_en;

         if (pop_pending && hs) begin
            if (occ == 2'd2) begin
               q0 <= q1;
               q1 <= din;
            end else begin
               q0 <= din;
            end
         end else if (hs) begin
            q0  <= q1;
            occ <= occ - 2'd1;
         end else if (pop_pending) begin
            if (occ == 2'd0) q0 <= din;
            else             q1 <= din;
            occ <= occ + 2'd1;
         end

         case ({hs, b_acc})
            2'b10:   outstanding <= outstanding + 8'd1;
            2'b01:   if (outstanding != 8'd0) outstanding <= outstanding - 8'd1;
            default: ;
         endcase

         if (b_acc && !hs && (outstanding == 8'd0)) err_unexp_b <= 1'b1;
         if (b_acc && (m_axi_bresp != 2'b00))       err_bresp   <= 1'b1;
      end
   end

endmodule

// File: tb/tb_awaddr_ddr_fifo_aw_issuer.sv
// Directed bench: instance A (default limit 8) covers reset/stream/backpressure/errors,
// instance B (limit 2) covers the outstanding-burst throttle.
module tb_awaddr_ddr_fifo_aw_issuer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic nxt;
      @(posedge clk); #1;
   endtask

   task automatic smp;
      @(negedge clk);
   endtask

   // ---------------- instance A ----------------
   logic [31:0] mem_a [64];
   int          wp_a = 0, rp_a = 0;
   logic [31:0] dat_a = '0;
   logic        empty_a, rd_en_a, awvalid_a, awready_a = 0, bvalid_a = 0, bready_a;
   logic [1:0]  bresp_a = 2'b00, burst_a;
   logic [3:0]  awid_a;
   logic [27:0] awaddr_a;
   logic [7:0]  awlen_a, out_a;
   logic [2:0]  awsize_a;
   logic        eb_a, eu_a, idle_a;

   assign empty_a = (rp_a == wp_a);
   always @(posedge clk) begin
      if (rst) rp_a <= wp_a;
      else if (rd_en_a) begin
         dat_a <= mem_a[rp_a];
         rp_a  <= rp_a + 1;
      end
   end

   awaddr_ddr_fifo_aw_issuer u_a (
      .rd_clk(clk), .rd_rst(rst), .fifo_rd_data(dat_a), .fifo_rd_empty(empty_a),
      .fifo_rd_en(rd_en_a), .m_axi_awid(awid_a), .m_axi_awaddr(awaddr_a), .m_axi_awlen(awlen_a),
      .m_axi_awsize(awsize_a), .m_axi_awburst(burst_a), .m_axi_awvalid(awvalid_a),
      .m_axi_awready(awready_a), .m_axi_bvalid(bvalid_a), .m_axi_bresp(bresp_a),
      .m_axi_bready(bready_a), .outstanding(out_a), .err_bresp(eb_a), .err_unexp_b(eu_a),
      .idle(idle_a));

   // ---------------- instance B ----------------
   logic [31:0] mem_b [16];
   int          wp_b = 0, rp_b = 0;
   logic [31:0] dat_b = '0;
   logic        empty_b, rd_en_b, awvalid_b, awready_b = 0, bvalid_b = 0, bready_b;
   logic [1:0]  burst_b;
   logic [3:0]  awid_b;
   logic [27:0] awaddr_b;
   logic [7:0]  awlen_b, out_b;
   logic [2:0]  awsize_b;
   logic        eb_b, eu_b, idle_b;

   assign empty_b = (rp_b == wp_b);
   always @(posedge clk) begin
      if (rst) rp_b <= wp_b;
      else if (rd_en_b) begin
         dat_b <= mem_b[rp_b];
         rp_b  <= rp_b + 1;
      end
   end

   awaddr_ddr_fifo_aw_issuer #(.c_MAX_OUTSTAND(2)) u_b (
      .rd_clk(clk), .rd_rst(rst), .fifo_rd_data(dat_b), .fifo_rd_empty(empty_b),
      .fifo_rd_en(rd_en_b), .m_axi_awid(awid_b), .m_axi_awaddr(awaddr_b), .m_axi_awlen(awlen_b),
      .m_axi_awsize(awsize_b), .m_axi_awburst(burst_b), .m_axi_awvalid(awvalid_b),
      .m_axi_awready(awready_b), .m_axi_bvalid(bvalid_b), .m_axi_bresp(2'b00),
      .m_axi_bready(bready_b), .outstanding(out_b), .err_bresp(eb_b), .err_unexp_b(eu_b),
      .idle(idle_b));

   task automatic push_a(input logic [3:0] len, input logic [27:0] addr);
      mem_a[wp_a] = {len, addr};
      wp_a++;
   endtask

   task automatic chk_reset_a(input string tag);
      chk({tag, "_awvalid"}, awvalid_a, 0);
      chk({tag, "_rd_en"},   rd_en_a,   0);
      chk({tag, "_bready"},  bready_a,  0);
      chk({tag, "_out"},     out_a,     0);
      chk({tag, "_awaddr"},  awaddr_a,  0);
      chk({tag, "_awlen"},   awlen_a,   0);
      chk({tag, "_errs"},    {eb_a, eu_a}, 0);
      chk({tag, "_idle"},    idle_a,    1);
   endtask

   int nb;

   initial begin
      // reset state and bready release
      repeat (2) nxt;
      smp;
      chk_reset_a("rst");
      chk("rst_consts", {awid_a, awsize_a, burst_a}, {4'd0, 3'd5, 2'b01});
      nxt; rst = 1'b0;
      smp; chk("rel_bready0", bready_a, 0);
      nxt; smp; chk("rel_bready1", bready_a, 1);

      // streaming: 6 words, awready high
      nxt;
      awready_a = 1'b1;
      for (int i = 1; i <= 6; i++) push_a(4'd3, 28'(i * 'h100));
      nb = 0;
      for (int k = 0; k < 12; k++) begin
         smp;
         if (k == 0) chk("t2_first_rd_en", rd_en_a, 1);
         if (awvalid_a) begin
            chk("t2_beat_cycle", k, 2 + nb);
            chk("t2_beat_addr", awaddr_a, 28'((nb + 1) * 'h100));
            chk("t2_beat_len", awlen_a, 3);
            nb++;
         end
         nxt;
      end
      chk("t2_beats", nb, 6);
      chk("t2_out", out_a, 6);
      bvalid_a = 1'b1;
      repeat (6) nxt;
      bvalid_a = 1'b0;
      smp;
      chk("t2_drained", out_a, 0);
      chk("t2_idle", idle_a, 1);
      chk("t2_no_err", {eb_a, eu_a}, 0);

      // backpressure: awready low, queue fills to 2
      nxt;
      awready_a = 1'b0;
      push_a(4'd5, 28'hA00); push_a(4'd5, 28'hB00); push_a(4'd5, 28'hC00);
      smp; chk("t3_rd_en_d0", rd_en_a, 1);
      nxt; smp; chk("t3_rd_en_d1", rd_en_a, 1);
      nxt; smp;
      chk("t3_awvalid_d2", awvalid_a, 1);
      chk("t3_rd_en_d2", rd_en_a, 0);
      for (int k = 3; k <= 6; k++) begin
         nxt; smp;
         chk("t3_hold_valid", awvalid_a, 1);
         chk("t3_hold_addr", awaddr_a, 28'hA00);
         chk("t3_hold_len", awlen_a, 5);
         chk("t3_full_rd_en", rd_en_a, 0);
      end
      nxt; awready_a = 1'b1;
      smp; chk("t3_rel_addr0", awaddr_a, 28'hA00); chk("t3_rel_rd_en", rd_en_a, 1);
      nxt; smp; chk("t3_rel_addr1", awaddr_a, 28'hB00); chk("t3_rel_v1", awvalid_a, 1);
      nxt; smp; chk("t3_rel_addr2", awaddr_a, 28'hC00); chk("t3_rel_v2", awvalid_a, 1);
      nxt; smp; chk("t3_done_v", awvalid_a, 0); chk("t3_out", out_a, 3);

      // simultaneous AW handshake and B at outstanding 3
      nxt; push_a(4'd1, 28'hD00);
      smp; chk("t5_rd_en", rd_en_a, 1);
      nxt;
      nxt; bvalid_a = 1'b1;
      smp; chk("t5_awvalid", awvalid_a, 1); chk("t5_out_pre", out_a, 3);
      nxt; bvalid_a = 1'b0;
      smp; chk("t5_out_post", out_a, 3); chk("t5_awvalid_off", awvalid_a, 0);

      // error flags
      nxt; bvalid_a = 1'b1; bresp_a = 2'b10;
      nxt; bresp_a = 2'b00;
      smp; chk("t6_err_bresp", eb_a, 1); chk("t6_out2", out_a, 2);
      nxt; smp; chk("t6_out1", out_a, 1);
      nxt; bvalid_a = 1'b0;
      smp; chk("t6_out0", out_a, 0); chk("t6_bresp_sticky", eb_a, 1); chk("t6_unexp0", eu_a, 0);
      nxt; bvalid_a = 1'b1;
      nxt; bvalid_a = 1'b0;
      smp; chk("t6_unexp", eu_a, 1); chk("t6_out_hold0", out_a, 0); chk("t6_bresp_keep", eb_a, 1);

      // reset mid-burst
      nxt; awready_a = 1'b0;
      push_a(4'd2, 28'hE00); push_a(4'd2, 28'hF00);
      nxt; nxt; smp;
      chk("t1_pre_awvalid", awvalid_a, 1);
      rst = 1'b1;
      #1;
      chk_reset_a("t1");
      nxt; rst = 1'b0;
      smp; chk("t1_bready0", bready_a, 0);
      nxt; smp; chk("t1_bready1", bready_a, 1); chk("t1_idle", idle_a, 1);
      chk("t1_rd_en", rd_en_a, 0);

      // throttle at limit 2 on instance B
      nxt;
      awready_b = 1'b1;
      for (int i = 0; i < 4; i++) begin
         mem_b[wp_b] = {4'd7, 28'(32'h1000 + i * 'h40)};
         wp_b++;
      end
      smp; chk("t4_rd_en", rd_en_b, 1);
      nxt; smp;
      nxt; smp; chk("t4_v_f2", awvalid_b, 1); chk("t4_addr_f2", awaddr_b, 28'h1000);
      nxt; smp; chk("t4_v_f3", awvalid_b, 1); chk("t4_out_f3", out_b, 1);
      nxt; smp; chk("t4_v_f4", awvalid_b, 0); chk("t4_out_f4", out_b, 2);
      nxt; smp; chk("t4_v_f5", awvalid_b, 0); chk("t4_out_f5", out_b, 2);
      chk("t4_rd_en_full", rd_en_b, 0);
      nxt; bvalid_b = 1'b1;
      nxt; bvalid_b = 1'b0;
      smp; chk("t4_out_b", out_b, 1); chk("t4_v_after_b", awvalid_b, 1);
      chk("t4_addr_after_b", awaddr_b, 28'h1080);
      nxt; smp; chk("t4_out_re", out_b, 2); chk("t4_v_re", awvalid_b, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
